retire_monitor: RTL and testbench

- Parametrised, synthesizable run monitor for the pipelined RISC-V core; replaces fixed five-index observation with configurable register shadows.
- Sits beside Top on the writeback/PC signals.
- Provides run control (start/halt/timeout FSM), cycle, retire and stall counters, and a buffered writeback trace FIFO drained by a ready/valid consumer.

---
 rtl/retire_monitor.sv | 149 ++++++++++++++
 tb/tb_retire_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// Run monitor beside the core's writeback/PC signals: start/halt/timeout control,
// RUN-time counters, register shadows and a writeback trace FIFO.
module retire_monitor #(
    parameter int XLEN        = 64,
    parameter int NUM_WATCH   = 5,
    parameter int TRACE_DEPTH = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [XLEN-1:0]           pc_in,
    input  logic [XLEN-1:0]           halt_pc,
    input  logic                      reg_write,
    input  logic [4:0]                rd,
    input  logic [XLEN-1:0]           write_data,
    input  logic                      trace_ready,
    output logic [1:0]                state,
    output logic                      done,
    output logic                      timeout,
    output logic [31:0]               cycle_count,
    output logic [31:0]               instr_count,
    output logic [31:0]               stall_count,
    output logic [NUM_WATCH*XLEN-1:0] watch_flat,
    output logic                      trace_valid,
    output logic [4:0]                trace_rd,
    output logic [XLEN-1:0]           trace_data,
    output logic                      trace_overflow
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t          r_state, w_next_state;
    logic [31:0]     r_cycle_count, r_instr_count, r_stall_count;
    logic [XLEN-1:0] r_prev_pc;
    logic [XLEN-1:0] r_watch     [NUM_WATCH];
    logic [4:0]      r_fifo_rd   [TRACE_DEPTH];
    logic [XLEN-1:0] r_fifo_data [TRACE_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    logic w_run, w_clear, w_accept, w_pop, w_full, w_push;

    assign w_run    = (r_state == S_RUN);
    assign w_clear  = start && !w_run;
    assign w_accept = w_run && reg_write && (rd != 5'd0);
    assign w_pop    = (r_count != '0) && trace_ready;
    assign w_full   = (r_count == CW'(TRACE_DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push   = w_accept && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves the target unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (pc_in == halt_pc)
                    w_next_state = S_DONE;
                else if (r_cycle_count >= 32'(TIMEOUT - 1))
                    w_next_state = S_TIMEOUT;
            end
            default: if (start) w_next_state = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else if (w_run) begin
            if (r_cycle_count != '1)                       r_cycle_count <= r_cycle_count + 32'd1;
            if (pc_in == r_prev_pc && r_stall_count != '1) r_stall_count <= r_stall_count + 32'd1;
            if (w_accept && r_instr_count != '1)           r_instr_count <= r_instr_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_prev_pc <= '0;
        else       r_prev_pc <= pc_in;
    end

    // x0 is never written because acceptance excludes rd == 0.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            for (int i = 0; i < NUM_WATCH; i++) r_watch[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WATCH; i++)
                if (w_accept && rd == 5'(i)) r_watch[i] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_accept && !w_push) r_overflow <= 1'b1;
        end
    end

    // NOTE: the storage is reset so the head fields read zero after reset/start rather than stale data.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= rd;
            r_fifo_data[r_wr_ptr] <= write_data;
        end
    end

    always_comb begin
        watch_flat = '0;
        for (int i = 0; i < NUM_WATCH; i++) watch_flat[i*XLEN +: XLEN] = r_watch[i];
    end

    assign state          = r_state;
    assign done           = (r_state == S_DONE);
    assign timeout        = (r_state == S_TIMEOUT);
    assign cycle_count    = r_cycle_count;
    assign instr_count    = r_instr_count;
    assign stall_count    = r_stall_count;
    assign trace_valid    = (r_count != '0);
    assign trace_rd       = r_fifo_rd[r_rd_ptr];
    assign trace_data     = r_fifo_data[r_rd_ptr];
    assign trace_overflow = r_overflow;
endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of the run monitor.
module tb_retire_monitor;
    localparam int XLEN  = 64;
    localparam int NW    = 5;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic            clk = 1'b0;
    logic            reset, start, reg_write, trace_ready;
    logic [XLEN-1:0] pc_in, halt_pc, write_data;
    logic [4:0]      rd;
    logic [1:0]      state;
    logic            done, timeout, trace_valid, trace_overflow;
    logic [31:0]     cycle_count, instr_count, stall_count;
    logic [NW*XLEN-1:0] watch_flat;
    logic [4:0]      trace_rd;
    logic [XLEN-1:0] trace_data;

    retire_monitor #(.XLEN(XLEN), .NUM_WATCH(NW), .TRACE_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .halt_pc(halt_pc),
        .reg_write(reg_write), .rd(rd), .write_data(write_data), .trace_ready(trace_ready),
        .state(state), .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .instr_count(instr_count), .stall_count(stall_count), .watch_flat(watch_flat),
        .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          m_q[$];
    int              m_state;
    logic [31:0]     m_cyc, m_ins, m_stl;
    logic [XLEN-1:0] m_sh [NW];
    logic [XLEN-1:0] m_prev;
    bit              m_ovf;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_clear();
        m_cyc = 0; m_ins = 0; m_stl = 0; m_ovf = 0;
        m_q.delete();
        for (int i = 0; i < NW; i++) m_sh[i] = '0;
    endtask

    // Apply the monitor's rules to the inputs sampled on this edge.
    task automatic model_edge();
        if (reset) begin
            model_clear();
            m_state = 0;
            m_prev  = '0;
        end else begin
            if (m_state != 1) begin
                if (start) begin
                    model_clear();
                    m_state = 1;
                end else if (trace_ready && m_q.size() > 0) begin
                    void'(m_q.pop_front());
                end
            end else begin
                if (trace_ready && m_q.size() > 0) void'(m_q.pop_front());
                m_cyc = sat_inc(m_cyc);
                if (pc_in == m_prev) m_stl = sat_inc(m_stl);
                if (reg_write && rd != 5'd0) begin
                    m_ins = sat_inc(m_ins);
                    if (int'(rd) < NW) m_sh[int'(rd)] = write_data;
                    if (m_q.size() < DEPTH) m_q.push_back('{rd, write_data});
                    else m_ovf = 1'b1;
                end
                if (pc_in == halt_pc)  m_state = 2;
                else if (m_cyc >= TMO) m_state = 3;
            end
            m_prev = pc_in;
        end
    endtask

    task automatic compare_all();
        check("state", 64'(state), 64'(m_state));
        check("done", 64'(done), 64'(m_state == 2));
        check("timeout", 64'(timeout), 64'(m_state == 3));
        check("cycle_count", 64'(cycle_count), 64'(m_cyc));
        check("instr_count", 64'(instr_count), 64'(m_ins));
        check("stall_count", 64'(stall_count), 64'(m_stl));
        for (int i = 0; i < NW; i++)
            check($sformatf("watch_x%0d", i), watch_flat[i*XLEN +: XLEN], m_sh[i]);
        check("trace_valid", 64'(trace_valid), 64'(m_q.size() != 0));
        check("trace_overflow", 64'(trace_overflow), 64'(m_ovf));
        if (m_q.size() != 0) begin
            check("trace_rd", 64'(trace_rd), 64'(m_q[0].rd));
            check("trace_data", trace_data, m_q[0].data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic quiet();
        start = 0; reg_write = 0; rd = '0; write_data = '0; trace_ready = 0;
    endtask

    task automatic adv();
        pc_in = pc_in + 64'd4;
    endtask

    task automatic wb(logic [4:0] r, logic [XLEN-1:0] d);
        reg_write = 1; rd = r; write_data = d; adv();
        step();
        reg_write = 0; rd = '0; write_data = '0;
    endtask

    task automatic do_start();
        start = 1; adv();
        step();
        start = 0;
    endtask

    task automatic do_halt();
        pc_in = halt_pc;
        step();
        pc_in = 64'h1000 + 64'(n_checks) * 64'd8;
    endtask

    initial begin
        reset = 1; quiet();
        pc_in = 64'h100; halt_pc = 64'h8000_0000;
        step();
        check("rst_trace_rd", 64'(trace_rd), 64'd0);
        check("rst_trace_data", trace_data, 64'd0);
        reset = 0;

        // Three writebacks then halt; drain in order.
        do_start();
        wb(5'd1, 64'd5); wb(5'd2, 64'd7); wb(5'd3, 64'd12);
        do_halt();
        check("t1_state", 64'(state), 64'd2);
        check("t1_done", 64'(done), 64'd1);
        check("t1_instr", 64'(instr_count), 64'd3);
        check("t1_x1", watch_flat[1*XLEN +: XLEN], 64'd5);
        check("t1_x2", watch_flat[2*XLEN +: XLEN], 64'd7);
        check("t1_x3", watch_flat[3*XLEN +: XLEN], 64'd12);
        check("t1_head1_rd", 64'(trace_rd), 64'd1);
        check("t1_head1_data", trace_data, 64'd5);
        trace_ready = 1; adv(); step();
        check("t1_head2_rd", 64'(trace_rd), 64'd2);
        check("t1_head2_data", trace_data, 64'd7);
        adv(); step();
        check("t1_head3_rd", 64'(trace_rd), 64'd3);
        check("t1_head3_data", trace_data, 64'd12);
        adv(); step();
        check("t1_drained", 64'(trace_valid), 64'd0);
        trace_ready = 0;

        // x0 is never accepted, x7 is counted and traced but not shadowed.
        do_start();
        wb(5'd0, 64'hFF); wb(5'd7, 64'h1234);
        do_halt();
        check("t2_x0", watch_flat[0 +: XLEN], 64'd0);
        check("t2_instr", 64'(instr_count), 64'd1);
        check("t2_head_rd", 64'(trace_rd), 64'd7);
        check("t2_head_data", trace_data, 64'h1234);
        trace_ready = 1; step(); trace_ready = 0;
        check("t2_one_entry", 64'(trace_valid), 64'd0);

        // Constant PC for ten RUN cycles, halt never hit: timeout after 20 cycles.
        start = 1; pc_in = 64'h4000; step(); start = 0;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 10; i++) begin adv(); step(); end
        check("t3_state", 64'(state), 64'd3);
        check("t3_cycles", 64'(cycle_count), 64'd20);
        check("t3_stall_ge9", 64'(stall_count >= 32'd9), 64'd1);
        for (int i = 0; i < 5; i++) wb(5'd2, 64'(i));
        check("t3_frozen_cycles", 64'(cycle_count), 64'd20);
        check("t3_frozen_instr", 64'(instr_count), 64'd0);

        // Overflow: five pushes into a four-entry FIFO with no consumer.
        do_start();
        for (int i = 1; i <= 5; i++) wb(5'(i), 64'(100 + i));
        check("t4_overflow", 64'(trace_overflow), 64'd1);
        do_halt();
        trace_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            check("t4_keep_valid", 64'(trace_valid), 64'd1);
            check("t4_keep_rd", 64'(trace_rd), 64'(i));
            step();
        end
        check("t4_keep_count", 64'(trace_valid), 64'd0);
        trace_ready = 0;

        // Same, but the fifth push coincides with a pop.
        do_start();
        for (int i = 1; i <= 4; i++) wb(5'(i), 64'(200 + i));
        trace_ready = 1; wb(5'd5, 64'd205); trace_ready = 0;
        check("t4b_no_overflow", 64'(trace_overflow), 64'd0);
        check("t4b_head_rd", 64'(trace_rd), 64'd2);
        do_halt();

        // Reset in the middle of a run with entries queued.
        do_start();
        wb(5'd1, 64'hAA); wb(5'd4, 64'hBB);
        check("t5_pre_valid", 64'(trace_valid), 64'd1);
        reset = 1; reg_write = 1; rd = 5'd3; write_data = 64'hCC; adv();
        step();
        reset = 0; reg_write = 0; rd = '0;
        check("t5_state", 64'(state), 64'd0);
        check("t5_cycles", 64'(cycle_count), 64'd0);
        check("t5_instr", 64'(instr_count), 64'd0);
        check("t5_stall", 64'(stall_count), 64'd0);
        check("t5_valid", 64'(trace_valid), 64'd0);
        check("t5_overflow", 64'(trace_overflow), 64'd0);
        check("t5_x1", watch_flat[1*XLEN +: XLEN], 64'd0);

        // Restart from DONE clears everything; halt and timeout together -> DONE.
        do_start();
        wb(5'd1, 64'h55); wb(5'd2, 64'h66);
        do_halt();
        do_start();
        check("t6_state", 64'(state), 64'd1);
        check("t6_cycles", 64'(cycle_count), 64'd0);
        check("t6_instr", 64'(instr_count), 64'd0);
        check("t6_x1", watch_flat[1*XLEN +: XLEN], 64'd0);
        for (int i = 0; i < TMO - 1; i++) begin adv(); step(); end
        do_halt();
        check("t6_done_wins", 64'(state), 64'd2);
        check("t6_cycles_end", 64'(cycle_count), 64'd20);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 249) == 0);
            start       = ($urandom_range(0, 9) == 0);
            reg_write   = $urandom_range(0, 1);
            rd          = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                       : 5'($urandom_range(0, 6));
            write_data  = {$urandom, $urandom};
            trace_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0)     pc_in = halt_pc;
            else if ($urandom_range(0, 3) != 0) pc_in = 64'h2000 + 64'(n) * 64'd4;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
